// File: rtl/heartbeat_scheduler.sv
// Heartbeat sequencer for the shared LED divider: LUB/GAP/DUB/REST at a BPM-derived beat length.
// Optional: define HB_BEAT_COUNT_EN to add the beat_count output.
module heartbeat_scheduler #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int TICK_HZ  = 1000,
  parameter int LUB_MS   = 100,
  parameter int GAP_MS   = 150,
  parameter int DUB_MS   = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  bpm_in,
  input  logic        bpm_load,
  output logic        bpm_ack,
  output logic        bpm_busy,
  output logic [3:0]  period,
  output logic [1:0]  phase,
  output logic        beat_active,
  output logic        beat_pulse
`ifdef HB_BEAT_COUNT_EN
  ,
  output logic [15:0] beat_count
`endif
);

  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [15:0] FIXED_MS = 16'(LUB_MS + GAP_MS + DUB_MS);

  typedef enum logic [2:0] {S_IDLE, S_LUB, S_GAP, S_DUB, S_REST} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [15:0]   ms_cnt;
  logic [15:0]   active_beat_ms;
  logic [15:0]   pending_beat_ms;
  logic [15:0]   dur;
  logic          tick;
  logic          last_ms;
  logic          enter_lub;

  always_comb begin
    dur = 16'd1;
    case (state)
      S_LUB:   dur = 16'(LUB_MS);
      S_GAP:   dur = 16'(GAP_MS);
      S_DUB:   dur = 16'(DUB_MS);
      S_REST:  dur = active_beat_ms - FIXED_MS;
      default: dur = 16'd1;
    endcase
  end

  assign tick      = (presc == PRESC_MAX);
  assign last_ms   = tick && (ms_cnt == dur - 16'd1);
  assign enter_lub = enable && ((state == S_IDLE) || ((state == S_REST) && last_ms));

  // Pattern FSM; the prescaler restarts on every LUB entry so each phase is an exact tick multiple.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      presc          <= '0;
      ms_cnt         <= '0;
      active_beat_ms <= 16'd1000;
      period         <= 4'd0;
      phase          <= 2'd0;
      beat_active    <= 1'b0;
      beat_pulse     <= 1'b0;
    end else begin
      beat_pulse <= 1'b0;
      if (!enable) begin
        state       <= S_IDLE;
        presc       <= '0;
        ms_cnt      <= '0;
        period      <= 4'd0;
        phase       <= 2'd0;
        beat_active <= 1'b0;
      end else if (enter_lub) begin
        if (state == S_REST) active_beat_ms <= pending_beat_ms;
        state       <= S_LUB;
        presc       <= '0;
        ms_cnt      <= '0;
        period      <= 4'd1;
        phase       <= 2'd0;
        beat_active <= 1'b1;
        beat_pulse  <= 1'b1;
      end else if (state != S_IDLE) begin
        presc <= tick ? '0 : presc + 1'b1;
        if (last_ms) begin
          ms_cnt <= '0;
          case (state)
            S_LUB: begin
              state  <= S_GAP;
              period <= 4'd4;
              phase  <= 2'd1;
            end
            S_GAP: begin
              state  <= S_DUB;
              period <= 4'd2;
              phase  <= 2'd2;
            end
            S_DUB: begin
              state  <= S_REST;
              period <= 4'd0;
              phase  <= 2'd3;
            end
            default: ;
          endcase
        end else if (tick) begin
          ms_cnt <= ms_cnt + 16'd1;
        end
      end
    end
  end

  // BPM -> ms: restoring division of 60000 by the clamped rate, one quotient bit per clock.
  logic [7:0]  bpm_clamp;
  logic [7:0]  div;
  logic [7:0]  rem;
  logic [15:0] dq;
  logic [3:0]  step;
  logic [8:0]  sh;
  logic        ge;
  logic [8:0]  diff;
  logic [7:0]  rem_nxt;
  logic [15:0] dq_nxt;

  always_comb begin
    bpm_clamp = bpm_in;
    if (bpm_in < 8'd40)       bpm_clamp = 8'd40;
    else if (bpm_in > 8'd170) bpm_clamp = 8'd170;
  end

  assign sh      = {rem, dq[15]};
  assign ge      = (sh >= {1'b0, div});
  assign diff    = sh - {1'b0, div};
  assign rem_nxt = ge ? diff[7:0] : sh[7:0];
  assign dq_nxt  = {dq[14:0], ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bpm_busy        <= 1'b0;
      bpm_ack         <= 1'b0;
      step            <= 4'd0;
      rem             <= 8'd0;
      dq              <= 16'd0;
      div             <= 8'd0;
      pending_beat_ms <= 16'd1000;
    end else begin
      bpm_ack <= 1'b0;
      if (!bpm_busy) begin
        if (bpm_load) begin
          bpm_busy <= 1'b1;
          step     <= 4'd0;
          rem      <= 8'd0;
          dq       <= 16'd60000;
          div      <= bpm_clamp;
        end
      end else begin
        rem  <= rem_nxt;
        dq   <= dq_nxt;
        step <= step + 4'd1;
        if (step == 4'd15) begin
          bpm_busy        <= 1'b0;
          bpm_ack         <= 1'b1;
          pending_beat_ms <= dq_nxt;
        end
      end
    end
  end

`ifdef HB_BEAT_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         beat_count <= 16'd0;
    else if (enter_lub) beat_count <= beat_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_heartbeat_scheduler.sv
// Directed bench for heartbeat_scheduler at TICK_DIV=12 (CLK_FREQ=12000, TICK_HZ=1000).
module tb_heartbeat_scheduler;

  logic       clk = 1'b0;
  logic       rst_n, enable, bpm_load, bpm_ack, bpm_busy, beat_active, beat_pulse;
  logic [7:0] bpm_in;
  logic [3:0] period;
  logic [1:0] phase;
`ifdef HB_BEAT_COUNT_EN
  logic [15:0] beat_count;
`endif

  int cyc = 0, total = 0, bad = 0;
  int pcount = 0, pcyc = 0, blen = 0;
  int ack_n = 0, ack_cyc = 0, load_cyc = 0, a0 = 0;

  heartbeat_scheduler #(.CLK_FREQ(12000), .TICK_HZ(1000)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bpm_in(bpm_in), .bpm_load(bpm_load),
    .bpm_ack(bpm_ack), .bpm_busy(bpm_busy), .period(period), .phase(phase),
    .beat_active(beat_active), .beat_pulse(beat_pulse)
`ifdef HB_BEAT_COUNT_EN
    , .beat_count(beat_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge, drop any load strobe, and log pulses/acks.
  task automatic tick();
    @(negedge clk);
    bpm_load = 1'b0;
    if (beat_pulse === 1'b1) begin
      blen = cyc - pcyc;
      pcyc = cyc;
      pcount++;
    end
    if (bpm_ack === 1'b1) begin
      ack_n++;
      ack_cyc = cyc;
    end
  endtask

  task automatic load(input logic [7:0] b);
    bpm_in   = b;
    bpm_load = 1'b1;
    load_cyc = cyc;
  endtask

  task automatic wait_beat(input string tag);
    int p0 = pcount;
    int n = 0;
    while (pcount == p0 && n < 25000) begin
      tick();
      n++;
    end
    chk({tag, "_wait"}, 32'(pcount != p0), 1);
  endtask

  task automatic wait_phase(input string tag, input logic [1:0] ph);
    int n = 0;
    while (phase !== ph && n < 25000) begin
      tick();
      n++;
    end
    chk({tag, "_phase_wait"}, 32'(phase === ph), 1);
  endtask

  // Called at the first cycle of a phase; returns at the first cycle of the next one.
  task automatic seg(input string tag, input int per, input int ph, input int len);
    int n = 1;
    chk({tag, "_period"}, 32'(period), per);
    chk({tag, "_phase"}, 32'(phase), ph);
    while (n < 25000) begin
      tick();
      if (period !== 4'(per)) break;
      n++;
    end
    chk({tag, "_len"}, n, len);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; bpm_load = 1'b0; bpm_in = 8'd0;
    repeat (3) tick();
    chk("rst_period", 32'(period), 0);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_active", 32'(beat_active), 0);
    chk("rst_pulse", 32'(beat_pulse), 0);
    chk("rst_ack", 32'(bpm_ack), 0);
    chk("rst_busy", 32'(bpm_busy), 0);
`ifdef HB_BEAT_COUNT_EN
    chk("rst_count", 32'(beat_count), 0);
`endif
    rst_n = 1'b1; enable = 1'b1;

    // Default 60 BPM beat with phase timing; a 120 BPM load lands during LUB.
    wait_beat("b1");
    chk("b1_active", 32'(beat_active), 1);
    load(8'd120);
    tick();
    chk("busy_after_load", 32'(bpm_busy), 1);
    seg("lub", 1, 0, 1199);
    seg("gap", 4, 1, 1800);
    seg("dub", 2, 2, 1200);
    seg("rest", 0, 3, 7800);
    chk("b2_pulse", 32'(beat_pulse), 1);
    chk("b1_len", blen, 12000);
    chk("ack_latency", ack_cyc - load_cyc, 17);
    chk("ack_count", ack_n, 1);
    tick();
    chk("pulse_width", 32'(beat_pulse), 0);

    // Beat 2 at 500 ms; second load while busy must be dropped.
    a0 = ack_n;
    load(8'd120);
    repeat (5) tick();
    chk("busy_mid", 32'(bpm_busy), 1);
    load(8'd90);
    repeat (40) tick();
    chk("two_loads_acks", ack_n - a0, 1);
    wait_phase("b2", 2'd3);
    seg("rest120", 0, 3, 1800);
    chk("b2_len", blen, 6000);

    // Beat 3 stays 500 (90 BPM was ignored); clamp tests follow.
    load(8'd200);
    wait_beat("b3");
    chk("b3_len", blen, 6000);
    load(8'd75);
    wait_phase("b4", 2'd3);
    seg("rest352", 0, 3, 24);
    chk("b4_len_352", blen, 4224);
    load(8'd10);
    wait_beat("b5");
    chk("b5_len_800", blen, 9600);
    wait_beat("b6");
    chk("b6_len_1500", blen, 18000);

    // Disable mid-DUB, then re-enable.
    wait_phase("b7", 2'd2);
    repeat (10) tick();
    enable = 1'b0;
    tick();
    chk("dis_period", 32'(period), 0);
    chk("dis_active", 32'(beat_active), 0);
    chk("dis_phase", 32'(phase), 0);
    repeat (5) tick();
    enable = 1'b1;
    tick();
    chk("re_pulse", 32'(beat_pulse), 1);
    chk("re_active", 32'(beat_active), 1);
    seg("relub", 1, 0, 1200);

    // Async reset mid-REST after another load; beat returns to 1000 ms.
    load(8'd120);
    wait_phase("b7r", 2'd3);
    repeat (100) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_period", 32'(period), 0);
    chk("arst_phase", 32'(phase), 0);
    chk("arst_active", 32'(beat_active), 0);
    chk("arst_busy", 32'(bpm_busy), 0);
`ifdef HB_BEAT_COUNT_EN
    chk("arst_count", 32'(beat_count), 0);
`endif
    tick();
    rst_n = 1'b1;
    wait_beat("r1");
`ifdef HB_BEAT_COUNT_EN
    chk("count_after_rst", 32'(beat_count), 1);
`endif
    wait_beat("r2");
    chk("post_rst_len", blen, 12000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/heartbeat_scheduler.md
Name: heartbeat_scheduler

Overview:
Sequences the shared LED clock divider to produce a heartbeat pattern: lub, gap, dub, rest.
- Drives the divider's 4-bit period select, where 1 = 600 Hz, 2 = 300 Hz, 3 = 200 Hz, 4 = 150 Hz, and 0 = divider held off.
- Beat rate is set in BPM. A sequential divider converts BPM to a beat length in ms.
- Sits between the top-level control/UI logic and the divider.

Parameters:
- CLK_FREQ, 12_000_000: system clock in Hz.
- TICK_HZ, 1000: time-base tick rate. TICK_DIV = CLK_FREQ/TICK_HZ clocks per tick.
- LUB_MS, 100: lub phase length in ticks.
- GAP_MS, 150: gap phase length in ticks.
- DUB_MS, 100: dub phase length in ticks.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  run the pattern; low forces IDLE
- bpm_in  in  8  requested beat rate; sampled on bpm_load
- bpm_load  in  1  single-cycle load strobe
- bpm_ack  out  1  one-cycle pulse when the new beat length is computed
- bpm_busy  out  1  conversion in progress
- period  out  4  period select to the clock divider
- phase  out  2  0 = lub, 1 = gap, 2 = dub, 3 = rest (0 also in IDLE)
- beat_active  out  1  high in any state except IDLE
- beat_pulse  out  1  one-cycle pulse on each entry to LUB

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, tick prescaler 0.
  - active_beat_ms = pending_beat_ms = 1000 (60 BPM).
  - Converter idle.
- Reset mid-operation aborts the converter and the pattern immediately (asynchronous).
- Tick prescaler:
  - Counts 0..TICK_DIV-1 and pulses tick on the wrap.
  - Cleared on every IDLE->LUB transition, so LUB lasts exactly LUB_MS*TICK_DIV clocks.
- Phase counter: ms_cnt is cleared on state entry and increments on tick. A state exits on the tick at which ms_cnt == duration-1.
- States (period / phase / duration):
  - IDLE: period 0 / phase 0 / —
  - LUB: period 1 / phase 0 / LUB_MS
  - GAP: period 4 / phase 1 / GAP_MS
  - DUB: period 2 / phase 2 / DUB_MS
  - REST: period 0 / phase 3 / active_beat_ms - (LUB_MS+GAP_MS+DUB_MS)
- Transitions:
  - IDLE->LUB on the first clock with enable=1.
  - LUB->GAP->DUB->REST->LUB on phase expiry.
  - On REST->LUB: active_beat_ms <= pending_beat_ms, and beat_pulse is asserted.
  - beat_pulse is also asserted on IDLE->LUB.
- Total beat length is exactly active_beat_ms ticks.
- enable=0 in any state: next clock goes to IDLE, period=0, beat_active=0, phase counter cleared. The converter is unaffected.
- Outputs are registered and change on the clock edge of the state change.
- BPM conversion:
  - bpm_load is accepted only when bpm_busy=0. Loads while busy are ignored and produce no ack.
  - Clamp: bpm_in <40 becomes 40; >170 becomes 170. Minimum beat length 352 ms exceeds the 350 ms of fixed phases.
  - Restoring division of 60000 by the clamped BPM: 16-bit quotient, one bit per clock, result floored.
  - Load sampled at cycle N: bpm_busy is high for N+1..N+16. At N+17, bpm_ack=1 for one cycle, pending_beat_ms = quotient, and bpm_busy=0.
  - The new value takes effect at the next REST->LUB boundary, never mid-beat.
  - A bpm_load coincident with bpm_ack is accepted, since busy is already low.

Optional Feature:
HB_BEAT_COUNT_EN
- Defined:
  - Adds output beat_count [15:0], reset to 0.
  - Increments on every beat_pulse and wraps 0xFFFF->0.
  - Holds its value through IDLE.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
Run with CLK_FREQ=12000 and TICK_HZ=1000, so TICK_DIV=12.
1. Release reset, enable=1 with the default rate:
   - beat_pulse every 12000 clocks.
   - period sequence 1 for 1200 clocks, 4 for 1800, 2 for 1200, 0 for 7800.
   - phase 0,1,2,3.
2. bpm_load with bpm_in=120 during LUB:
   - bpm_ack exactly 17 clocks later.
   - The current beat is still 12000 clocks.
   - The next beat is 6000 clocks, with REST = 150 ticks.
3. Clamping:
   - bpm_in=200 gives beat length 352 ticks, REST 2 ticks.
   - bpm_in=10 gives 1500 ticks.
   - bpm_in=75 gives 800 ticks.
4. Two loads 5 clocks apart (bpm 120, then 90): only one ack, and the pending value is 500.
5. enable=0 mid-DUB:
   - Next clock: period=0, beat_active=0.
   - Re-enable: beat_pulse on the following clock and a full 1200-clock LUB.
6. rst_n asserted mid-REST:
   - Outputs go to 0 without a clock edge.
   - After release with enable=1, the beat length is 1000 ticks regardless of earlier loads.
   - With HB_BEAT_COUNT_EN defined, beat_count restarts at 0.
